// File: rtl/side_buffer_reinject.sv
// Side buffer that holds flits diverted by the redirect stage and reinjects them
// into free output slots (priority N > S > E > W), with starvation escalation.
module side_buffer_reinject #(
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [10:0]              buffit,
    input  logic                     buffit_vld,
    input  logic [10:0]              nad_in,
    input  logic [10:0]              sad_in,
    input  logic [10:0]              ead_in,
    input  logic [10:0]              wad_in,
    input  logic                     nad_vld_in,
    input  logic                     sad_vld_in,
    input  logic                     ead_vld_in,
    input  logic                     wad_vld_in,
    output logic [10:0]              nad,
    output logic [10:0]              sad,
    output logic [10:0]              ead,
    output logic [10:0]              wad,
    output logic                     nad_vld,
    output logic                     sad_vld,
    output logic                     ead_vld,
    output logic                     wad_vld,
    output logic                     buf_full,
    output logic [$clog2(DEPTH):0]   buf_cnt,
    output logic                     force_redirect,
    output logic                     overflow
);

    localparam int FW    = 11;
    localparam int NSLOT = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int SW    = $clog2(STARVE_LIM + 1);

    // Slot index 0 is N, 1 is S, 2 is E, 3 is W; lower index wins a pop.
    logic [FW-1:0]    slot_in [NSLOT];
    logic [NSLOT-1:0] vld_in;

    assign slot_in[0] = nad_in;
    assign slot_in[1] = sad_in;
    assign slot_in[2] = ead_in;
    assign slot_in[3] = wad_in;
    assign vld_in     = {wad_vld_in, ead_vld_in, sad_vld_in, nad_vld_in};

    logic [FW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             full_q, full_d;
    logic             force_q, force_d;
    logic             ovf_q, ovf_d;
    logic [FW-1:0]    slot_q [NSLOT];
    logic [FW-1:0]    slot_d [NSLOT];
    logic [NSLOT-1:0] slot_vld_q, slot_vld_d;

    logic [NSLOT-1:0] free_slots;
    logic [NSLOT-1:0] pop_sel;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [FW-1:0]    head;

    // Occupancy decisions use the registered count, so a flit written this
    // cycle can never be popped in the same cycle.
    always_comb begin
        free_slots = ~vld_in;
        pop_sel    = free_slots & (~free_slots + NSLOT'(1));
        fifo_full  = (cnt_q == CW'(DEPTH));
        pop        = (cnt_q != '0) && (|free_slots);
        push       = buffit_vld && (!fifo_full || pop);
        drop       = buffit_vld && fifo_full && !pop;
        head       = mem_q[rd_ptr_q];
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        full_d = (cnt_d == CW'(DEPTH));
        ovf_d  = ovf_q | drop;
    end

    // Starvation only accumulates while flits wait and every slot is taken.
    always_comb begin
        starve_d = starve_q;
        if (pop || (cnt_q == '0)) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
        end
        force_d = (starve_d == SW'(STARVE_LIM));
    end

    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            slot_d[i]     = slot_in[i];
            slot_vld_d[i] = vld_in[i];
            if (pop && pop_sel[i]) begin
                slot_d[i]     = head;
                slot_vld_d[i] = 1'b1;
            end
        end
    end

    // Storage array carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= buffit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            starve_q   <= '0;
            full_q     <= 1'b0;
            force_q    <= 1'b0;
            ovf_q      <= 1'b0;
            slot_vld_q <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            full_q     <= full_d;
            force_q    <= force_d;
            ovf_q      <= ovf_d;
            slot_vld_q <= slot_vld_d;
            for (int i = 0; i < NSLOT; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign nad            = slot_q[0];
    assign sad            = slot_q[1];
    assign ead            = slot_q[2];
    assign wad            = slot_q[3];
    assign nad_vld        = slot_vld_q[0];
    assign sad_vld        = slot_vld_q[1];
    assign ead_vld        = slot_vld_q[2];
    assign wad_vld        = slot_vld_q[3];
    assign buf_full       = full_q;
    assign buf_cnt        = cnt_q;
    assign force_redirect = force_q;
    assign overflow       = ovf_q;

endmodule

// File: doc/side_buffer_reinject.md
SIDE_BUFFER_REINJECT -- requirements
Module: side_buffer_reinject

Interface
REQ-001 Parameter DEPTH, default 4, meaning side-buffer FIFO entries; legal values are powers of two, 2..16.
REQ-002 Parameter STARVE_LIM, default 8, meaning consecutive blocked cycles before force_redirect asserts.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 buffit  input  11  flit diverted by the redirect stage into the side buffer.
REQ-006 buffit_vld  input  1  buffit carries a flit this cycle.
REQ-007 nad_in, sad_in, ead_in, wad_in  input  11 each  slot flits from the redirect stage.
REQ-008 nad_vld_in, sad_vld_in, ead_vld_in, wad_vld_in  input  1 each  slot occupied.
REQ-009 nad, sad, ead, wad  output  11 each  registered slot flits after reinjection.
REQ-010 nad_vld, sad_vld, ead_vld, wad_vld  output  1 each  registered slot occupied.
REQ-011 buf_full  output  1  FIFO holds DEPTH entries.
REQ-012 buf_cnt  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-013 force_redirect  output  1  request to the redirect stage to divert one flit so that a slot frees up.
REQ-014 overflow  output  1  sticky flag: a push was lost.

Function
REQ-015 Slot outputs: registered, latency exactly 1 cycle; each output equals its input unless that slot receives a reinjected flit.
REQ-016 Free slot: a slot whose *_vld_in is 0 in the current cycle.
REQ-017 Pop: when buf_cnt>0 and at least one slot is free, pop the FIFO head into the first free slot, priority N > S > E > W.
REQ-018 Pop count: at most one pop per cycle; a popped flit drives the chosen slot with vld=1 on the next cycle.
REQ-019 Push: when buffit_vld=1 and the FIFO is not full after this cycle's pop, write buffit at the tail.
REQ-020 No bypass: a flit pushed in cycle t is poppable no earlier than cycle t+1.
REQ-021 Simultaneous push and pop: buf_cnt is unchanged; this is legal when full (pop frees the entry).
REQ-022 Full: push while full with no pop in the same cycle drops buffit and sets overflow=1; overflow stays 1 until reset.
REQ-023 Ordering: strict FIFO; read and write pointers wrap modulo DEPTH without losing or duplicating entries.
REQ-024 Starvation counter, reset to 0:
  - increments each cycle buf_cnt>0 and no slot is free;
  - clears on any pop or when buf_cnt=0;
  - saturates at STARVE_LIM.
REQ-025 force_redirect: registered, 1 while the counter equals STARVE_LIM; deasserts the cycle after the first subsequent pop.
REQ-026 buf_full and buf_cnt: registered, reflecting occupancy after the current cycle's push and pop.
REQ-027 Flit contents: passed bit-exact; never decoded or modified.

Reset
REQ-028 With rst_n=0 at a rising edge, the following clear on that edge: FIFO pointers, buf_cnt, starvation counter, overflow, buf_full, force_redirect, all slot outputs, and all *_vld outputs (to 0).
REQ-029 Reset mid-operation discards buffered flits; the first push after rst_n returns high is accepted normally.

Verification
REQ-030 Pass-through: empty FIFO; nad_in=11'h424 (vld), others invalid -> next cycle nad=11'h424, nad_vld=1, sad/ead/wad_vld=0.
REQ-031 Push then reinject: buffit=11'h005 pushed in cycle 0; in cycle 1 all slots free except N -> cycle 2 sad=11'h005, sad_vld=1, buf_cnt=0.
REQ-032 Order and wrap: push 6 flits 11'h001..11'h006 with pops interleaved -> they reappear in order 1..6, pointers wrap, overflow=0.
REQ-033 Full and drop: fill with 4 flits, all slots busy, push 11'h7FF -> buf_full=1, overflow=1, buf_cnt=4, 11'h7FF never appears; a simultaneous push+pop when full -> no overflow.
REQ-034 Starvation: buf_cnt=1, all four slots valid for 8 cycles -> force_redirect=1 after the 8th blocked cycle; free W slot -> flit pops to wad, force_redirect=0 on the following cycle.
REQ-035 Reset mid-operation: buf_cnt=3, assert rst_n=0 for one edge -> all outputs 0 next cycle; subsequent push of 11'h0AA reinjects correctly.
